// File: rtl/mesi_cbus_agent_if.sv
// CPU request, main-bus and coherence-bus signals of one MESI CPU agent.
// master = the agent, slave = the CPU/ISC side driving it.
interface mesi_cbus_agent_if #(
    parameter int ADDR_WIDTH     = 32,
    parameter int MBUS_CMD_WIDTH = 3,
    parameter int CBUS_CMD_WIDTH = 3
);
    logic                      req_valid_i;
    logic                      req_wr_i;
    logic [ADDR_WIDTH-1:0]     req_addr_i;
    logic                      req_ready_o;
    logic                      done_o;
    logic [MBUS_CMD_WIDTH-1:0] mbus_cmd_o;
    logic [ADDR_WIDTH-1:0]     mbus_addr_o;
    logic                      mbus_ack_i;
    logic [CBUS_CMD_WIDTH-1:0] cbus_cmd_i;
    logic [ADDR_WIDTH-1:0]     cbus_addr_i;
    logic                      cbus_ack_o;

    modport master (
        input  req_valid_i, req_wr_i, req_addr_i, mbus_ack_i, cbus_cmd_i, cbus_addr_i,
        output req_ready_o, done_o, mbus_cmd_o, mbus_addr_o, cbus_ack_o
    );

    modport slave (
        output req_valid_i, req_wr_i, req_addr_i, mbus_ack_i, cbus_cmd_i, cbus_addr_i,
        input  req_ready_o, done_o, mbus_cmd_o, mbus_addr_o, cbus_ack_o
    );
endinterface

// File: rtl/mesi_cbus_agent.sv
// Per-CPU MESI coherence agent: direct-mapped line-state table, upstream
// broadcast/write-back commands, and servicing of ISC snoop/enable commands.
module mesi_cbus_agent #(
    parameter int ADDR_WIDTH     = 32,
    parameter int MBUS_CMD_WIDTH = 3,
    parameter int CBUS_CMD_WIDTH = 3,
    parameter int LINES          = 4,
    parameter int LINES_LOG2     = 2,
    parameter int SNOOP_LAT      = 2
) (
    input logic               clk,
    input logic               rst,
    mesi_cbus_agent_if.master bus
);
    localparam int          TAG_W    = ADDR_WIDTH - LINES_LOG2;
    localparam int unsigned WAIT_CYC = (SNOOP_LAT > 1) ? SNOOP_LAT - 1 : 0;
    localparam int          CNT_W    = $clog2(SNOOP_LAT + 1);

    localparam logic [MBUS_CMD_WIDTH-1:0] MB_NOP      = '0;
    localparam logic [MBUS_CMD_WIDTH-1:0] MB_WR       = MBUS_CMD_WIDTH'(1);
    localparam logic [MBUS_CMD_WIDTH-1:0] MB_WR_BROAD = MBUS_CMD_WIDTH'(3);
    localparam logic [MBUS_CMD_WIDTH-1:0] MB_RD_BROAD = MBUS_CMD_WIDTH'(4);
    localparam logic [CBUS_CMD_WIDTH-1:0] CB_WR_SNOOP = CBUS_CMD_WIDTH'(1);
    localparam logic [CBUS_CMD_WIDTH-1:0] CB_RD_SNOOP = CBUS_CMD_WIDTH'(2);
    localparam logic [CBUS_CMD_WIDTH-1:0] CB_EN_WR    = CBUS_CMD_WIDTH'(3);
    localparam logic [CBUS_CMD_WIDTH-1:0] CB_EN_RD    = CBUS_CMD_WIDTH'(4);

    typedef enum logic [1:0] {LS_I, LS_S, LS_E, LS_M} line_e;
    typedef enum logic [2:0] {
        IDLE, HIT, WB_VICT, BROAD, WAIT_EN, SNP_WAIT, SNP_WB, SNP_ACK
    } state_e;

    state_e                state_q, state_d, ret_q, ret_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d, snp_addr_q, snp_addr_d;
    logic                  wr_q, wr_d, snp_wr_q, snp_wr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  en_q, en_d;
    logic                  ign_q;
    logic [TAG_W-1:0]      tag_q [LINES];
    line_e                 st_q  [LINES];

    logic                  tbl_we;
    logic [LINES_LOG2-1:0] tbl_idx;
    logic [TAG_W-1:0]      tbl_tag;
    line_e                 tbl_st;

    logic [LINES_LOG2-1:0] req_idx, lat_idx, snp_idx, cb_idx;
    logic [TAG_W-1:0]      req_tag, lat_tag, snp_tag, cb_tag;
    logic                  req_hit, snp_hit, snp_hit_m, cb_hit_m;
    logic                  cbus_live, is_snoop, is_en, snp_take;
    state_e                snp_entry;

    assign req_idx = bus.req_addr_i[LINES_LOG2-1:0];
    assign req_tag = bus.req_addr_i[ADDR_WIDTH-1:LINES_LOG2];
    assign lat_idx = addr_q[LINES_LOG2-1:0];
    assign lat_tag = addr_q[ADDR_WIDTH-1:LINES_LOG2];
    assign snp_idx = snp_addr_q[LINES_LOG2-1:0];
    assign snp_tag = snp_addr_q[ADDR_WIDTH-1:LINES_LOG2];
    assign cb_idx  = bus.cbus_addr_i[LINES_LOG2-1:0];
    assign cb_tag  = bus.cbus_addr_i[ADDR_WIDTH-1:LINES_LOG2];

    assign req_hit   = (st_q[req_idx] != LS_I) && (tag_q[req_idx] == req_tag);
    assign snp_hit   = (st_q[snp_idx] != LS_I) && (tag_q[snp_idx] == snp_tag);
    assign snp_hit_m = snp_hit && (st_q[snp_idx] == LS_M);
    assign cb_hit_m  = (st_q[cb_idx] == LS_M) && (tag_q[cb_idx] == cb_tag);

    assign bus.done_o     = (state_q == HIT) || en_q;
    assign bus.cbus_ack_o = (state_q == SNP_ACK) || en_q;

    // The ISC holds a command until it sees our ack, so commands are masked
    // during the ack cycle and the one after it.
    assign cbus_live = !(bus.cbus_ack_o || ign_q);
    assign is_snoop  = (bus.cbus_cmd_i == CB_WR_SNOOP) || (bus.cbus_cmd_i == CB_RD_SNOOP);
    assign is_en     = (bus.cbus_cmd_i == CB_EN_WR) || (bus.cbus_cmd_i == CB_EN_RD);
    assign snp_take  = cbus_live && is_snoop && ((state_q == IDLE) || (state_q == WAIT_EN));
    assign snp_entry = (WAIT_CYC == 0) ? (cb_hit_m ? SNP_WB : SNP_ACK) : SNP_WAIT;

    always_comb begin
        state_d         = state_q;
        ret_d           = ret_q;
        addr_d          = addr_q;
        wr_d            = wr_q;
        snp_addr_d      = snp_addr_q;
        snp_wr_d        = snp_wr_q;
        cnt_d           = cnt_q;
        en_d            = 1'b0;
        tbl_we          = 1'b0;
        tbl_idx         = lat_idx;
        tbl_tag         = tag_q[lat_idx];
        tbl_st          = st_q[lat_idx];
        bus.req_ready_o = 1'b0;
        bus.mbus_cmd_o  = MB_NOP;
        bus.mbus_addr_o = '0;

        if (snp_take) begin
            state_d    = snp_entry;
            ret_d      = state_q;
            snp_addr_d = bus.cbus_addr_i;
            snp_wr_d   = (bus.cbus_cmd_i == CB_WR_SNOOP);
            cnt_d      = CNT_W'(1);
        end else begin
            unique case (state_q)
                IDLE: begin
                    bus.req_ready_o = 1'b1;
                    if (bus.req_valid_i) begin
                        addr_d = bus.req_addr_i;
                        wr_d   = bus.req_wr_i;
                        if (req_hit && (!bus.req_wr_i || st_q[req_idx] == LS_E ||
                                        st_q[req_idx] == LS_M))
                            state_d = HIT;
                        else if (!req_hit && st_q[req_idx] == LS_M)
                            state_d = WB_VICT;
                        else
                            state_d = BROAD;
                    end
                end
                HIT: begin
                    if (wr_q) begin
                        tbl_we = 1'b1;
                        tbl_st = LS_M;
                    end
                    state_d = IDLE;
                end
                WB_VICT: begin
                    bus.mbus_cmd_o  = MB_WR;
                    bus.mbus_addr_o = {tag_q[lat_idx], lat_idx};
                    if (bus.mbus_ack_i) begin
                        tbl_we  = 1'b1;
                        tbl_st  = LS_I;
                        state_d = BROAD;
                    end
                end
                BROAD: begin
                    bus.mbus_cmd_o  = wr_q ? MB_WR_BROAD : MB_RD_BROAD;
                    bus.mbus_addr_o = addr_q;
                    if (bus.mbus_ack_i) state_d = WAIT_EN;
                end
                WAIT_EN: begin
                    if (cbus_live && is_en) begin
                        en_d    = 1'b1;
                        tbl_we  = 1'b1;
                        tbl_tag = lat_tag;
                        tbl_st  = wr_q ? LS_M : LS_S;
                        state_d = IDLE;
                    end
                end
                SNP_WAIT: begin
                    if (cnt_q == CNT_W'(WAIT_CYC))
                        state_d = snp_hit_m ? SNP_WB : SNP_ACK;
                    else
                        cnt_d = cnt_q + CNT_W'(1);
                end
                SNP_WB: begin
                    bus.mbus_cmd_o  = MB_WR;
                    bus.mbus_addr_o = snp_addr_q;
                    if (bus.mbus_ack_i) state_d = SNP_ACK;
                end
                SNP_ACK: begin
                    if (snp_hit) begin
                        tbl_we  = 1'b1;
                        tbl_idx = snp_idx;
                        tbl_tag = tag_q[snp_idx];
                        tbl_st  = snp_wr_q ? LS_I : LS_S;
                    end
                    state_d = ret_q;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            ret_q      <= IDLE;
            addr_q     <= '0;
            wr_q       <= 1'b0;
            snp_addr_q <= '0;
            snp_wr_q   <= 1'b0;
            cnt_q      <= '0;
            en_q       <= 1'b0;
            ign_q      <= 1'b0;
            for (int unsigned i = 0; i < unsigned'(LINES); i++) begin
                tag_q[i] <= '0;
                st_q[i]  <= LS_I;
            end
        end else begin
            state_q    <= state_d;
            ret_q      <= ret_d;
            addr_q     <= addr_d;
            wr_q       <= wr_d;
            snp_addr_q <= snp_addr_d;
            snp_wr_q   <= snp_wr_d;
            cnt_q      <= cnt_d;
            en_q       <= en_d;
            ign_q      <= bus.cbus_ack_o;
            if (tbl_we) begin
                tag_q[tbl_idx] <= tbl_tag;
                st_q[tbl_idx]  <= tbl_st;
            end
        end
    end
endmodule

// File: tb/tb_mesi_cbus_agent.sv
// Bench for mesi_cbus_agent: directed scenarios plus randomized loads, stores
// and snoops checked against a line-level cache model.
module tb_mesi_cbus_agent;
    localparam int AW = 32;
    localparam int SL = 2;
    localparam int LN = 4;
    localparam int L_I = 0, L_S = 1, L_E = 2, L_M = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mesi_cbus_agent_if #(.ADDR_WIDTH(AW), .MBUS_CMD_WIDTH(3), .CBUS_CMD_WIDTH(3)) bus ();

    mesi_cbus_agent #(
        .ADDR_WIDTH(AW), .MBUS_CMD_WIDTH(3), .CBUS_CMD_WIDTH(3),
        .LINES(LN), .LINES_LOG2(2), .SNOOP_LAT(SL)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int failures = 0;

    // Model: which full address each line holds, and its MESI state.
    int unsigned maddr [LN];
    int          mst   [LN];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic model_reset();
        for (int i = 0; i < LN; i++) begin
            maddr[i] = 0;
            mst[i]   = L_I;
        end
    endtask

    function automatic int unsigned pick_addr();
        return ($urandom_range(0, 2) << 2) | $urandom_range(0, 3);
    endfunction

    task automatic idle(input int n, input bit exp_ready);
        for (int k = 0; k < n; k++) begin
            bus.mbus_ack_i = 1'($urandom_range(0, 1));
            #1;
            chk("idle_ready", bus.req_ready_o, exp_ready);
            chk("idle_mbus", bus.mbus_cmd_o, 0);
            chk("idle_done", bus.done_o, 0);
            chk("idle_cack", bus.cbus_ack_o, 0);
            step();
        end
        bus.mbus_ack_i = 1'b0;
    endtask

    task automatic mbus_xfer(input string tag, input int cmd, input int unsigned addr);
        chk({tag, "_cmd"}, bus.mbus_cmd_o, cmd);
        chk({tag, "_addr"}, bus.mbus_addr_o, addr);
        repeat ($urandom_range(0, 2)) begin
            step();
            chk({tag, "_hold"}, bus.mbus_cmd_o, cmd);
            chk({tag, "_nodone"}, bus.done_o, 0);
        end
        bus.mbus_ack_i = 1'b1;
        step();
        bus.mbus_ack_i = 1'b0;
    endtask

    task automatic snoop(input bit in_idle, input bit wr, input int unsigned addr);
        int idx = int'(addr % LN);
        bit hit = (mst[idx] != L_I) && (maddr[idx] == addr);
        bit dirty = hit && (mst[idx] == L_M);
        bus.cbus_cmd_i  = wr ? 3'd1 : 3'd2;
        bus.cbus_addr_i = addr;
        if (in_idle) begin
            #1;
            chk("snp_ready_low", bus.req_ready_o, 0);
        end
        step();
        for (int k = 1; k < SL; k++) begin
            chk("snp_wait_ack", bus.cbus_ack_o, 0);
            step();
        end
        if (dirty) begin
            chk("snp_wb_noack", bus.cbus_ack_o, 0);
            mbus_xfer("snp_wb", 1, addr);
        end
        chk("snp_ack", bus.cbus_ack_o, 1);
        chk("snp_ack_mbus", bus.mbus_cmd_o, 0);
        bus.cbus_cmd_i = 3'd0;
        if (hit) mst[idx] = wr ? L_I : L_S;
        step();
        chk("snp_ack_pulse", bus.cbus_ack_o, 0);
        step();
    endtask

    task automatic enable(input bit wr, input int unsigned addr);
        int idx = int'(addr % LN);
        chk("en_pre_done", bus.done_o, 0);
        bus.cbus_cmd_i  = wr ? 3'd3 : 3'd4;
        bus.cbus_addr_i = $urandom;
        step();
        chk("en_ack", bus.cbus_ack_o, 1);
        chk("en_done", bus.done_o, 1);
        bus.cbus_cmd_i = 3'd0;
        maddr[idx] = addr;
        mst[idx]   = wr ? L_M : L_S;
        step();
        chk("en_ack_pulse", bus.cbus_ack_o, 0);
        chk("en_done_pulse", bus.done_o, 0);
        step();
    endtask

    task automatic do_req(input bit wr, input int unsigned addr, input int snp_pct,
                          input bit snp_wr, input int unsigned snp_addr);
        int idx = int'(addr % LN);
        bit hit = (mst[idx] != L_I) && (maddr[idx] == addr);
        bus.req_valid_i = 1'b1;
        bus.req_wr_i    = wr;
        bus.req_addr_i  = addr;
        #1;
        chk("req_ready", bus.req_ready_o, 1);
        step();
        bus.req_valid_i = 1'b0;
        if (hit && (!wr || mst[idx] == L_M || mst[idx] == L_E)) begin
            chk("hit_done", bus.done_o, 1);
            chk("hit_mbus", bus.mbus_cmd_o, 0);
            chk("hit_busy", bus.req_ready_o, 0);
            if (wr) mst[idx] = L_M;
            step();
            chk("hit_done_pulse", bus.done_o, 0);
            chk("hit_ready", bus.req_ready_o, 1);
        end else begin
            chk("miss_nodone", bus.done_o, 0);
            if (!hit && mst[idx] == L_M) begin
                mbus_xfer("vict", 1, maddr[idx]);
                mst[idx] = L_I;
            end
            mbus_xfer("broad", wr ? 3 : 4, addr);
            chk("broad_nop", bus.mbus_cmd_o, 0);
            if ($urandom_range(0, 99) < snp_pct) snoop(1'b0, snp_wr, snp_addr);
            idle($urandom_range(0, 2), 1'b0);
            enable(wr, addr);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned a;
        rst = 1'b1;
        bus.req_valid_i = 1'b0;
        bus.req_wr_i    = 1'b0;
        bus.req_addr_i  = '0;
        bus.mbus_ack_i  = 1'b0;
        bus.cbus_cmd_i  = '0;
        bus.cbus_addr_i = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        chk("rst_mbus_cmd", bus.mbus_cmd_o, 0);
        chk("rst_mbus_addr", bus.mbus_addr_o, 0);
        chk("rst_cbus_ack", bus.cbus_ack_o, 0);
        chk("rst_done", bus.done_o, 0);
        rst = 1'b0;
        #1;
        chk("rst_ready", bus.req_ready_o, 1);
        step();

        do_req(1'b0, 32'h10, 0, 1'b0, 0);
        do_req(1'b1, 32'h10, 0, 1'b0, 0);
        do_req(1'b0, 32'h10, 0, 1'b0, 0);
        do_req(1'b0, 32'h14, 0, 1'b0, 0);
        do_req(1'b1, 32'h10, 0, 1'b0, 0);
        snoop(1'b1, 1'b0, 32'h10);
        do_req(1'b0, 32'h10, 0, 1'b0, 0);
        do_req(1'b1, 32'h10, 100, 1'b1, 32'h99);
        idle(2, 1'b1);

        // Reset while a broadcast is outstanding.
        bus.req_valid_i = 1'b1;
        bus.req_wr_i    = 1'b0;
        bus.req_addr_i  = 32'h23;
        step();
        bus.req_valid_i = 1'b0;
        chk("pre_rst_broad", bus.mbus_cmd_o, 4);
        step();
        #1 rst = 1'b1;
        #1;
        chk("midrst_mbus", bus.mbus_cmd_o, 0);
        chk("midrst_done", bus.done_o, 0);
        chk("midrst_cack", bus.cbus_ack_o, 0);
        step();
        rst = 1'b0;
        model_reset();
        #1;
        chk("postrst_ready", bus.req_ready_o, 1);
        chk("postrst_done", bus.done_o, 0);
        step();
        do_req(1'b0, 32'h10, 0, 1'b0, 0);

        for (int it = 0; it < 150; it++) begin
            idle($urandom_range(0, 2), 1'b1);
            if ($urandom_range(0, 99) < 25) begin
                a = ($urandom_range(0, 1) == 1) ? maddr[$urandom_range(0, LN - 1)] : pick_addr();
                snoop(1'b1, 1'($urandom_range(0, 1)), a);
            end else begin
                a = ($urandom_range(0, 1) == 1) ? maddr[$urandom_range(0, LN - 1)] : pick_addr();
                do_req(1'($urandom_range(0, 1)), pick_addr(), 30, 1'($urandom_range(0, 1)), a);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
